// File: rtl/iq_frame_buffer.sv
// IQ sample FIFO between the DDC clock domain and an I2S transmitter; one sample popped per I2S frame.
// Optional statistics counters are built when IQ_FRAME_BUFFER_STATS_EN is defined.
module iq_frame_buffer #(
  parameter int DW = 24,
  parameter int AW = 3
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          in_strobe,
  input  logic [DW-1:0] in_real,
  input  logic [DW-1:0] in_imag,
  input  logic          lrclk,
  input  logic          clr_flags,
  output logic [DW-1:0] out_real,
  output logic [DW-1:0] out_imag,
  output logic [AW:0]   fill,
  output logic          overflow,
  output logic          underflow
`ifdef IQ_FRAME_BUFFER_STATS_EN
  ,
  output logic [7:0]    ovf_count,
  output logic [7:0]    unf_count
`endif
);

  localparam int DEPTH = 1 << AW;

  typedef enum logic {PRIME, RUN} state_t;

  state_t            state, state_next;
  logic              sync1, sync2, sync3, pop_req;
  logic [2*DW-1:0]   mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic              full, empty, push_ok, pop_ok, ovf_evt, unf_evt;

  always_comb begin
    full       = 1'b0;
    empty      = 1'b0;
    push_ok    = 1'b0;
    pop_ok     = 1'b0;
    ovf_evt    = 1'b0;
    unf_evt    = 1'b0;
    state_next = state;
    full       = (fill == (AW+1)'(DEPTH));
    empty      = (fill == '0);
    pop_ok     = pop_req && (state == RUN) && !empty;
    unf_evt    = pop_req && (state == RUN) && empty;
    // A pop in the same cycle frees the slot the push needs when full.
    push_ok    = in_strobe && (!full || pop_ok);
    ovf_evt    = in_strobe && full && !pop_ok;
    case (state)
      PRIME:   if (fill >= (AW+1)'(DEPTH/2)) state_next = RUN;
      RUN:     if (unf_evt) state_next = PRIME;
      default: state_next = PRIME;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= PRIME;
    else        state <= state_next;
  end

  // Two-flop synchronizer, third flop for edge detect, then a registered frame pulse.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1   <= 1'b1;
      sync2   <= 1'b1;
      sync3   <= 1'b1;
      pop_req <= 1'b0;
    end else begin
      sync1   <= lrclk;
      sync2   <= sync1;
      sync3   <= sync2;
      pop_req <= sync3 & ~sync2;
    end
  end

  always_ff @(posedge clock) begin
    if (push_ok) mem[wr_ptr] <= {in_real, in_imag};
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      fill      <= '0;
      out_real  <= '0;
      out_imag  <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok) begin
        rd_ptr               <= rd_ptr + 1'b1;
        {out_real, out_imag} <= mem[rd_ptr];
      end
      case ({push_ok, pop_ok})
        2'b10:   fill <= fill + 1'b1;
        2'b01:   fill <= fill - 1'b1;
        default: fill <= fill;
      endcase
      if (ovf_evt)        overflow <= 1'b1;
      else if (clr_flags) overflow <= 1'b0;
      if (unf_evt)        underflow <= 1'b1;
      else if (clr_flags) underflow <= 1'b0;
    end
  end

`ifdef IQ_FRAME_BUFFER_STATS_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ovf_count <= '0;
      unf_count <= '0;
    end else begin
      if (clr_flags)                        ovf_count <= ovf_evt ? 8'd1 : 8'd0;
      else if (ovf_evt && ovf_count != 8'hFF) ovf_count <= ovf_count + 8'd1;
      if (clr_flags)                        unf_count <= unf_evt ? 8'd1 : 8'd0;
      else if (unf_evt && unf_count != 8'hFF) unf_count <= unf_count + 8'd1;
    end
  end
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_iq_frame_buffer.sv
// Directed bench for iq_frame_buffer: prime, latency, overflow, underflow, simultaneous push/pop, wrap, reset.
module tb_iq_frame_buffer;
  localparam int DW = 24;
  localparam int AW = 3;

  logic          clock = 1'b0;
  logic          reset;
  logic          in_strobe;
  logic [DW-1:0] in_real, in_imag;
  logic          lrclk;
  logic          clr_flags;
  logic [DW-1:0] out_real, out_imag;
  logic [AW:0]   fill;
  logic          overflow, underflow;
`ifdef IQ_FRAME_BUFFER_STATS_EN
  logic [7:0]    ovf_count, unf_count;
`endif

  int total = 0;
  int bad   = 0;

  iq_frame_buffer #(.DW(DW), .AW(AW)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_strobe (in_strobe),
    .in_real   (in_real),
    .in_imag   (in_imag),
    .lrclk     (lrclk),
    .clr_flags (clr_flags),
    .out_real  (out_real),
    .out_imag  (out_imag),
    .fill      (fill),
    .overflow  (overflow),
    .underflow (underflow)
`ifdef IQ_FRAME_BUFFER_STATS_EN
    ,
    .ovf_count (ovf_count),
    .unf_count (unf_count)
`endif
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input logic [DW-1:0] v);
    in_strobe = 1'b1;
    in_real   = v;
    in_imag   = v ^ 24'hA00000;
    tick();
    in_strobe = 1'b0;
  endtask

  // lrclk falls; the pop happens on the 4th edge, optionally with a push in that same cycle.
  task automatic frame(input bit do_push, input logic [DW-1:0] v);
    lrclk = 1'b0;
    tick(); tick(); tick();
    if (do_push) begin
      in_strobe = 1'b1;
      in_real   = v;
      in_imag   = v ^ 24'hA00000;
    end
    tick();
    in_strobe = 1'b0;
    lrclk = 1'b1;
    tick(); tick(); tick();
  endtask

  task automatic pulse_clr();
    clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;
  endtask

  initial begin
    reset = 1'b0; lrclk = 1'b1; in_strobe = 1'b0; clr_flags = 1'b0;
    in_real = '0; in_imag = '0;
    #12;
    chk("rst_out_real", out_real, 0);
    chk("rst_out_imag", out_imag, 0);
    chk("rst_fill", fill, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_underflow", underflow, 0);
    @(posedge clock); #1 reset = 1'b1;
    tick(); tick();

    // Prime: three samples are not enough to start popping
    push(24'h000001); push(24'h000002); push(24'h000003);
    chk("prime_fill3", fill, 3);
    frame(1'b0, '0);
    chk("prime_out_held", out_real, 0);
    chk("prime_no_unf", underflow, 0);
    push(24'h000004); tick();
    chk("prime_fill4", fill, 4);

    // Latency: output changes on exactly the 4th edge
    lrclk = 1'b0;
    tick(); tick(); tick();
    chk("lat_edge3", out_real, 0);
    tick();
    chk("lat_edge4_re", out_real, 24'h000001);
    chk("lat_edge4_im", out_imag, 24'hA00001);
    lrclk = 1'b1;
    tick(); tick(); tick();
    chk("lat_fill", fill, 3);

    for (int v = 2; v <= 4; v++) begin
      frame(1'b0, '0);
      chk("drain", out_real, 48'(v));
    end

    // Underflow: pop on empty in RUN holds outputs and drops to PRIME
    frame(1'b0, '0);
    chk("unf_hold", out_real, 24'h000004);
    chk("unf_flag", underflow, 1);
    chk("unf_fill", fill, 0);
    pulse_clr();
    chk("unf_clr", underflow, 0);
    frame(1'b0, '0);
    chk("prime_pop_ignored", out_real, 24'h000004);
    chk("prime_pop_no_flag", underflow, 0);

    // Overflow: nine pushes, ninth (0x19) dropped
    for (int i = 0; i < 9; i++) push(24'(32'h11 + i));
    chk("ovf_fill", fill, 8);
    chk("ovf_flag", overflow, 1);
    tick();
    pulse_clr();
    chk("ovf_clr", overflow, 0);

    // Simultaneous push and pop at full
    frame(1'b1, 24'h00001A);
    chk("full_both_out", out_real, 24'h000011);
    chk("full_both_fill", fill, 8);
    chk("full_both_no_ovf", overflow, 0);
    for (int i = 0; i < 8; i++) begin
      frame(1'b0, '0);
      chk("ovf_order", out_real, (i < 7) ? 48'(32'h12 + i) : 48'h1A);
    end
    chk("drained_fill", fill, 0);
    chk("drained_no_unf", underflow, 0);

    // Simultaneous push and pop at empty in RUN: push lands, pop underflows, no bypass
    frame(1'b1, 24'h00001B);
    chk("empty_both_fill", fill, 1);
    chk("empty_both_unf", underflow, 1);
    chk("empty_both_hold", out_real, 24'h00001A);
    pulse_clr();

    // Wrap: steady stream one-in one-out across many pointer wraps
    push(24'h00001C); push(24'h00001D); push(24'h00001E); tick();
    chk("wrap_start_fill", fill, 4);
    for (int i = 0; i < 100; i++) begin
      frame(1'b1, 24'(32'h1F + i));
      chk("wrap_re", out_real, 48'(32'h1B + i));
      if (i == 50) chk("wrap_im", out_imag, 48'((32'h1B + i) ^ 32'hA00000));
    end
    chk("wrap_fill", fill, 4);
    chk("wrap_no_ovf", overflow, 0);
    chk("wrap_no_unf", underflow, 0);

    // Asynchronous reset mid-stream clears outputs without a clock edge
    @(posedge clock);
    #3 reset = 1'b0;
    #1;
    chk("arst_out_real", out_real, 0);
    chk("arst_out_imag", out_imag, 0);
    chk("arst_fill", fill, 0);
    @(posedge clock); #1 reset = 1'b1;
    tick(); tick(); tick();
    push(24'h000050); push(24'h000051); push(24'h000052); push(24'h000053); tick();
    frame(1'b0, '0);
    chk("post_rst_out", out_real, 24'h000050);
    chk("post_rst_fill", fill, 3);

`ifdef IQ_FRAME_BUFFER_STATS_EN
    for (int i = 0; i < 305; i++) push(24'(32'h60 + i));
    chk("stat_ovf_count", ovf_count, 8'd255);
    chk("stat_ovf_flag", overflow, 1);
    pulse_clr();
    chk("stat_ovf_count_clr", ovf_count, 0);
    chk("stat_ovf_flag_clr", overflow, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/iq_frame_buffer.md
IQ_FRAME_BUFFER -- requirements
Module: iq_frame_buffer

Interface
REQ-001 Parameter DW, default 24: I/Q sample width in bits.
REQ-002 Parameter AW, default 3: FIFO address width; depth = 2^AW = 8 entries.
REQ-003 Port clock, input, 1: DDC clock; all logic is on its rising edge.
REQ-004 Port reset, input, 1: asynchronous, active-low reset.
REQ-005 Port in_strobe, input, 1: one-cycle valid for in_real and in_imag.
REQ-006 Port in_real, input, DW: DDC I sample (two's complement).
REQ-007 Port in_imag, input, DW: DDC Q sample (two's complement).
REQ-008 Port lrclk, input, 1: I2S word-select from the BCLK domain; asynchronous to clock.
REQ-009 Port clr_flags, input, 1: synchronous clear of the sticky flags.
REQ-010 Port out_real, output, DW: held I sample feeding the I2S transmitter.
REQ-011 Port out_imag, output, DW: held Q sample feeding the I2S transmitter.
REQ-012 Port fill, output, AW+1: current FIFO occupancy, 0..2^AW.
REQ-013 Port overflow, output, 1: sticky flag, a push was dropped.
REQ-014 Port underflow, output, 1: sticky flag, a pop found the FIFO empty while in RUN.

Function
REQ-015 Synchronizer: lrclk SHALL pass through a 2-flop synchronizer, then a third flop for edge detection.
REQ-016 Frame pulse: one-cycle pop request on each synchronized lrclk 1->0 transition (I2S frame start).
REQ-017 Push: in_strobe with FIFO not full writes {in_real,in_imag} at the write pointer; write pointer +1, wrapping modulo 2^AW.
REQ-018 Push when full, with no pop in the same cycle: sample dropped, FIFO unchanged, overflow set.
REQ-019 Pop in RUN with FIFO not empty: head loaded into out_real/out_imag on the next edge; read pointer +1, wrapping.
REQ-020 Pop in RUN with FIFO empty: outputs hold their previous value, underflow set, state goes to PRIME.
REQ-021 Pop in PRIME: ignored; outputs hold; no flag set.
REQ-022 Push and pop in the same cycle, FIFO full: both succeed; fill unchanged; no overflow.
REQ-023 Push and pop in the same cycle, FIFO empty: push succeeds; pop is an underflow per REQ-020; no bypass to the outputs.
REQ-024 States: PRIME moves to RUN when fill >= 2^(AW-1) (4 by default); RUN moves to PRIME only per REQ-020.
REQ-025 Latency: lrclk falling at the pin to out_* update is exactly 4 clock edges when the FIFO is non-empty in RUN.
REQ-026 Outputs out_* SHALL change only on a successful pop and stay stable for the whole I2S frame.
REQ-027 fill: registered; +1 on push only, -1 on pop only, unchanged on both or neither.
REQ-028 clr_flags: clears overflow and underflow next edge; a flag-setting event in the same cycle wins.

Reset
REQ-029 reset low SHALL asynchronously force: out_real=0, out_imag=0, fill=0, overflow=0, underflow=0, both pointers=0, state=PRIME, and all synchronizer flops=1.
REQ-030 Reset asserted mid-operation discards all FIFO contents; no pop may occur in the first 3 cycles after release.

Configuration
REQ-031 Macro IQ_FRAME_BUFFER_STATS_EN defined: adds output ports ovf_count[7:0] and unf_count[7:0].
REQ-032 ovf_count and unf_count count overflow and underflow events respectively, saturate at 255, reset to 0, and are cleared by clr_flags.
REQ-033 Macro IQ_FRAME_BUFFER_STATS_EN undefined: these ports and counters are absent; all other behaviour is identical.

Verification
REQ-034 Prime: after reset, push 0x000001..0x000003 and toggle lrclk -> outputs stay 0 and underflow stays 0; the 4th push moves state to RUN; the next lrclk fall gives out_real=0x000001 at 4 edges.
REQ-035 Overflow: 9 pushes with no pops -> fill=8, overflow=1, 9th sample absent; pops return samples 1..8 in order.
REQ-036 Underflow: in RUN, drain to empty, then one more lrclk fall -> outputs hold the last sample, underflow=1, state PRIME.
REQ-037 Simultaneous: at fill=8, push and pop in the same cycle -> fill stays 8, overflow=0; at fill=0 in RUN -> fill=1, underflow=1.
REQ-038 Wrap: stream 100 pushes and pops at an equal rate -> output sequence is exact with no flags across pointer wrap-around; an async reset mid-stream gives all outputs 0 immediately.
REQ-039 With the macro defined: 300 dropped pushes -> ovf_count=255; clr_flags pulse -> ovf_count=0 and overflow=0.
